// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit family: parity codes,
// receiver state encoding and a baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_WAIT_HIGH
    } rx_state_t;

    // Rounded Clk cycles per oversample tick, minus one (the Baud_Div encoding).
    function automatic int baud_div_for(input int clk_hz, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den - 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-Clk Tick every Div+1 cycles, phase-restartable.
`timescale 1ns/1ps
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Restart,
    input  logic [DIV_W-1:0] Div,
    output logic             Tick
);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: flops use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
        end else if (Restart || div_cnt >= Div) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign Tick = !Restart && (div_cnt == Div);

endmodule

// File: rtl/uart_frame_rx.sv
// Configurable UART frame receiver: 3-sample majority vote per bit, parity/
// framing/break detection and a one-entry valid/ready holding register.
`timescale 1ns/1ps
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DIV_W      = 16
)(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DIV_W-1:0]     Baud_Div,
    input  logic [1:0]           Parity_Mode,
    input  logic                 Stop2,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Break_Det,
    output logic                 Overrun
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);

    localparam logic [SC_W-1:0] CAP_A    = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] CAP_B    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] CAP_C    = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0] SAMP_END = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

    rx_state_t state, state_nxt;

    logic rx_s1, rx_s2, rx_prev;
    logic fall, start_det, tick;
    logic cap_first, cap_mid, cap_last, bit_end;
    logic cap_a, cap_b, vote;

    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_par;
    logic             cfg_stop2;
    logic             par_on;

    logic [SC_W-1:0]      samp_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_acc, frame_err_acc, zero_acc;
    logic                 done, done_q;
    logic                 brk_final, fe_final;
    logic                 res_pe, res_fe, res_bd;

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall      = rx_prev && !rx_s2;
    assign start_det = (state == ST_IDLE) && fall;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .Clk     (Clk),
        .Reset   (Reset),
        .Restart (start_det),
        .Div     (cfg_div),
        .Tick    (tick)
    );

    assign cap_first = tick && (samp_cnt == CAP_A);
    assign cap_mid   = tick && (samp_cnt == CAP_B);
    assign cap_last  = tick && (samp_cnt == CAP_C);
    assign bit_end   = tick && (samp_cnt == SAMP_END);

    assign vote      = (cap_a & cap_b) | (cap_a & rx_s2) | (cap_b & rx_s2);
    assign par_on    = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
    assign brk_final = zero_acc && !vote;
    assign fe_final  = frame_err_acc || !vote;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:   if (fall) state_nxt = ST_START;
            ST_START: begin
                if (cap_last && vote) state_nxt = ST_IDLE;
                else if (bit_end)     state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == LAST_BIT)
                    state_nxt = par_on ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: if (bit_end) state_nxt = ST_STOP1;
            ST_STOP1: begin
                // Single stop completes at its last capture to catch an immediate next start.
                if (!cfg_stop2) begin
                    if (cap_last) done = 1'b1;
                end else if (bit_end) begin
                    state_nxt = ST_STOP2;
                end
            end
            ST_STOP2:     if (cap_last) done = 1'b1;
            ST_WAIT_HIGH: if (rx_s2) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (done) state_nxt = brk_final ? ST_WAIT_HIGH : ST_IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cfg_div       <= '0;
            cfg_par       <= PAR_NONE;
            cfg_stop2     <= 1'b0;
            samp_cnt      <= '0;
            bit_cnt       <= '0;
            cap_a         <= 1'b0;
            cap_b         <= 1'b0;
            shift_reg     <= '0;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
            zero_acc      <= 1'b0;
            done_q        <= 1'b0;
            res_pe        <= 1'b0;
            res_fe        <= 1'b0;
            res_bd        <= 1'b0;
        end else begin
            done_q <= done;
            if (start_det) begin
                cfg_div       <= Baud_Div;
                cfg_par       <= Parity_Mode;
                cfg_stop2     <= Stop2;
                samp_cnt      <= '0;
                bit_cnt       <= '0;
                par_err_acc   <= 1'b0;
                frame_err_acc <= 1'b0;
                zero_acc      <= 1'b1;
            end else if (tick) begin
                samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + SC_W'(1);
            end

            if (cap_first) cap_a <= rx_s2;
            if (cap_mid)   cap_b <= rx_s2;

            if (cap_last) begin
                case (state)
                    ST_DATA: begin
                        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                        zero_acc  <= zero_acc && !vote;
                    end
                    ST_PARITY: begin
                        par_err_acc <= ((^shift_reg) ^ vote) != (cfg_par == PAR_ODD);
                        zero_acc    <= zero_acc && !vote;
                    end
                    ST_STOP1: begin
                        frame_err_acc <= frame_err_acc || !vote;
                        zero_acc      <= zero_acc && !vote;
                    end
                    default: ;
                endcase
            end

            if (state == ST_DATA && bit_end) bit_cnt <= bit_cnt + BC_W'(1);

            if (done) begin
                res_pe <= par_err_acc;
                res_fe <= fe_final;
                res_bd <= brk_final;
            end
        end
    end

    // Holding register: a full, unaccepted register keeps its frame and drops the new one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data       <= '0;
            Rx_Valid   <= 1'b0;
            Parity_Err <= 1'b0;
            Frame_Err  <= 1'b0;
            Break_Det  <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            Overrun <= 1'b0;
            if (done_q && (!Rx_Valid || Rx_Ready)) begin
                Data       <= shift_reg;
                Parity_Err <= res_pe;
                Frame_Err  <= res_fe;
                Break_Det  <= res_bd;
                Rx_Valid   <= 1'b1;
            end else if (done_q) begin
                Overrun <= 1'b1;
            end else if (Rx_Valid && Rx_Ready) begin
                Rx_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: an 8-bit and a 9-bit instance on separate
// serial lines, expected frames queued at stimulus time and popped on handshake.
`timescale 1ns/1ps
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int OS     = 16;
    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Baud_Div;
    logic [1:0]  Parity_Mode;
    logic        Stop2;
    logic        Rx_Ready;
    logic        line8, line9;

    logic [7:0] Data8;
    logic       Rx_Valid8, Parity_Err8, Frame_Err8, Break_Det8, Overrun8;
    logic [8:0] Data9;
    logic       Rx_Valid9, Parity_Err9, Frame_Err9, Break_Det9, Overrun9;

    int   checks   = 0;
    int   failures = 0;
    int   bit_clks;
    int   ov_cnt8  = 0;
    int   ov_cnt9  = 0;
    exp_t q8[$];
    exp_t q9[$];

    always #10 Clk = ~Clk;

    uart_frame_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .DIV_W(16)) dut8 (
        .Clk(Clk), .Reset(Reset), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
        .Stop2(Stop2), .uart_rx(line8), .Data(Data8), .Rx_Valid(Rx_Valid8),
        .Rx_Ready(Rx_Ready), .Parity_Err(Parity_Err8), .Frame_Err(Frame_Err8),
        .Break_Det(Break_Det8), .Overrun(Overrun8)
    );

    uart_frame_rx #(.DATA_BITS(9), .OVERSAMPLE(OS), .DIV_W(16)) dut9 (
        .Clk(Clk), .Reset(Reset), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
        .Stop2(Stop2), .uart_rx(line9), .Data(Data9), .Rx_Valid(Rx_Valid9),
        .Rx_Ready(Rx_Ready), .Parity_Err(Parity_Err9), .Frame_Err(Frame_Err9),
        .Break_Det(Break_Det9), .Overrun(Overrun9)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void expect_frame(input int sel, input logic [8:0] d,
                                         input logic pe, input logic fe, input logic bd);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bd = bd;
        if (sel == 9) q9.push_back(e);
        else          q8.push_back(e);
    endfunction

    task automatic drive_line(input int sel, input logic v, input int clks);
        @(posedge Clk); #1;
        if (sel == 9) line9 = v;
        else          line8 = v;
        repeat (clks - 1) @(posedge Clk);
    endtask

    // par_bit < 0 means no parity bit on the wire.
    task automatic send_frame(input int sel, input logic [8:0] val, input int nbits,
                              input int par_bit, input int nstop);
        drive_line(sel, 1'b0, bit_clks);
        for (int i = 0; i < nbits; i++) drive_line(sel, val[i], bit_clks);
        if (par_bit >= 0) drive_line(sel, par_bit[0], bit_clks);
        for (int i = 0; i < nstop; i++) drive_line(sel, 1'b1, bit_clks);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q8.size() != 0 || q9.size() != 0) && n < 3000) begin
            @(posedge Clk);
            n++;
        end
        check(name, q8.size() + q9.size(), 0);
        repeat (4) @(posedge Clk);
    endtask

    // Monitor for the 8-bit instance.
    logic acc_prev8 = 1'b0;
    always @(negedge Clk) begin
        if (Reset) begin
            acc_prev8 = 1'b0;
        end else begin
            if (acc_prev8) check("valid_clear8", Rx_Valid8, 0);
            acc_prev8 = 1'b0;
            if (Overrun8) ov_cnt8++;
            if (Rx_Valid8 && Rx_Ready) begin
                if (q8.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious8: got frame 0x%0h expected none", Data8);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("data8", Data8, e.data);
                    check("parity_err8", Parity_Err8, e.pe);
                    check("frame_err8", Frame_Err8, e.fe);
                    check("break_det8", Break_Det8, e.bd);
                end
                acc_prev8 = 1'b1;
            end
        end
    end

    // Monitor for the 9-bit instance.
    logic acc_prev9 = 1'b0;
    always @(negedge Clk) begin
        if (Reset) begin
            acc_prev9 = 1'b0;
        end else begin
            if (acc_prev9) check("valid_clear9", Rx_Valid9, 0);
            acc_prev9 = 1'b0;
            if (Overrun9) ov_cnt9++;
            if (Rx_Valid9 && Rx_Ready) begin
                if (q9.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious9: got frame 0x%0h expected none", Data9);
                end else begin
                    exp_t e;
                    e = q9.pop_front();
                    check("data9", Data9, e.data);
                    check("parity_err9", Parity_Err9, e.pe);
                    check("frame_err9", Frame_Err9, e.fe);
                    check("break_det9", Break_Det9, e.bd);
                end
                acc_prev9 = 1'b1;
            end
        end
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_base;
        Reset       = 1'b1;
        line8       = 1'b1;
        line9       = 1'b1;
        Rx_Ready    = 1'b1;
        Parity_Mode = PAR_NONE;
        Stop2       = 1'b0;
        Baud_Div    = 16'(baud_div_for(CLK_HZ, BAUD, OS));
        bit_clks    = (int'(Baud_Div) + 1) * OS;

        repeat (5) @(negedge Clk);
        check("reset_out8", {Data8, Rx_Valid8, Parity_Err8, Frame_Err8, Break_Det8, Overrun8}, 0);
        check("reset_out9", {Data9, Rx_Valid9, Parity_Err9, Frame_Err9, Break_Det9, Overrun9}, 0);
        check("reset_state8", dut8.state, ST_IDLE);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (20) @(posedge Clk);

        // 1: plain 8N1
        expect_frame(8, 9'h0A5, 0, 0, 0);
        send_frame(8, 9'h0A5, 8, -1, 1);
        wait_drain("s1_drain");

        // 2: even parity, wrong then correct parity bit
        Parity_Mode = PAR_EVEN;
        expect_frame(8, 9'h037, 1, 0, 0);
        send_frame(8, 9'h037, 8, 0, 1);
        expect_frame(8, 9'h037, 0, 0, 0);
        send_frame(8, 9'h037, 8, 1, 1);
        wait_drain("s2_drain");
        Parity_Mode = PAR_NONE;

        // 3: false start glitch
        drive_line(8, 1'b0, 135);
        drive_line(8, 1'b1, bit_clks);
        check("s3_idle", dut8.state, ST_IDLE);
        check("s3_no_valid", Rx_Valid8, 0);
        expect_frame(8, 9'h03C, 0, 0, 0);
        send_frame(8, 9'h03C, 8, -1, 1);
        wait_drain("s3_drain");

        // 4: break condition
        expect_frame(8, 9'h000, 0, 1, 1);
        drive_line(8, 1'b0, 20 * bit_clks);
        check("s4_wait_high", dut8.state, ST_WAIT_HIGH);
        check("s4_break_seen", q8.size(), 0);
        drive_line(8, 1'b1, bit_clks);
        expect_frame(8, 9'h055, 0, 0, 0);
        send_frame(8, 9'h055, 8, -1, 1);
        wait_drain("s4_drain");

        // 5: overrun with consumer stalled
        @(posedge Clk); #1 Rx_Ready = 1'b0;
        ov_base = ov_cnt8;
        expect_frame(8, 9'h011, 0, 0, 0);
        send_frame(8, 9'h011, 8, -1, 1);
        send_frame(8, 9'h022, 8, -1, 1);
        @(negedge Clk);
        check("s5_overrun_pulses", ov_cnt8 - ov_base, 1);
        check("s5_data_held", Data8, 8'h11);
        check("s5_valid_held", Rx_Valid8, 1);
        @(posedge Clk); #1 Rx_Ready = 1'b1;
        wait_drain("s5_drain");
        check("s5_valid_fell", Rx_Valid8, 0);

        // 6: reset in the middle of data bit 3, then a 9-bit two-stop frame
        fork
            send_frame(8, 9'h0F0, 8, -1, 1);
            begin
                repeat (4 * bit_clks + bit_clks / 2) @(posedge Clk);
                #1 Reset = 1'b1;
                @(negedge Clk);
                check("s6_rst_out8", {Data8, Rx_Valid8, Parity_Err8, Frame_Err8, Break_Det8, Overrun8}, 0);
                check("s6_rst_out9", {Data9, Rx_Valid9, Parity_Err9, Frame_Err9, Break_Det9, Overrun9}, 0);
                repeat (bit_clks) @(posedge Clk);
                #1 Reset = 1'b0;
            end
        join
        drive_line(8, 1'b1, bit_clks);
        check("s6_no_frame8", Rx_Valid8, 0);
        Stop2 = 1'b1;
        expect_frame(9, 9'h181, 0, 0, 0);
        send_frame(9, 9'h181, 9, -1, 2);
        wait_drain("s6_drain");
        check("s6_overrun9", ov_cnt9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
